// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM multicycle control unit.
package arm_ctrl_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned COND_W = 4;
  localparam int unsigned CMD_W  = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
  localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Raw per-state control word produced by the main FSM, before condition gating.
  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
  } fsm_ctrl_t;

endpackage

// File: rtl/arm_mc_ctrl_if.sv
// Instruction-field / control-select bundle between the datapath and the control unit.
interface arm_mc_ctrl_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
    input  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
    output ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/cond_unit.sv
// NZCV flag register, condition-code evaluation and the per-instruction condex latch.
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [1:0]        flag_w,
  input  logic              flag_en,
  input  logic              cond_latch,
  output logic              condex_q
);

  logic [FLAG_W-1:0] flags_q;
  logic              n, z, c, v;
  logic              condex_c;

  assign {n, z, c, v} = flags_q;

  // Condition check against the architectural flags.
  always_comb begin
    condex_c = 1'b0;
    case (cond)
      COND_EQ: condex_c = z;
      COND_NE: condex_c = ~z;
      COND_CS: condex_c = c;
      COND_CC: condex_c = ~c;
      COND_MI: condex_c = n;
      COND_PL: condex_c = ~n;
      COND_VS: condex_c = v;
      COND_VC: condex_c = ~v;
      COND_HI: condex_c = c & ~z;
      COND_LS: condex_c = ~c | z;
      COND_GE: condex_c = (n == v);
      COND_LT: condex_c = (n != v);
      COND_GT: condex_c = ~z & (n == v);
      COND_LE: condex_c = z | (n != v);
      COND_AL: condex_c = 1'b1;
      default: condex_c = 1'b0;
    endcase
  end

  // N,Z and C,V are written independently so logical ops can leave C,V alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      if (cond_latch) condex_q <= condex_c;
      if (flag_en && condex_q) begin
        if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
        if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM control unit: main FSM, ALU/immediate decode and conditional write gating.
module arm_mc_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  arm_mc_ctrl_if.slave  bus
);

  state_t            state_q, state_d;
  fsm_ctrl_t         ctrl;
  logic [CMD_W-1:0]  cmd;
  logic [1:0]        alu_control;
  logic [1:0]        flag_w;
  logic              no_write;
  logic              pcs;
  logic              condex_q;
  logic              flag_en;
  logic              cond_latch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next state and raw control word for the current step.
  always_comb begin
    state_d = S_FETCH;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        state_d         = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.adr_src = 1'b1;
        state_d      = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_b = SRCB_RM;
        ctrl.alu_op    = 1'b1;
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALURESULT;
        ctrl.branch     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign cmd = bus.Funct[4:1];

  // ALU decode; non-ALUOp steps use add.
  always_comb begin
    alu_control = 2'b00;
    flag_w      = 2'b00;
    if (ctrl.alu_op) begin
      case (cmd)
        CMD_ADD: begin alu_control = 2'b00; flag_w = 2'b11; end
        CMD_SUB: begin alu_control = 2'b01; flag_w = 2'b11; end
        CMD_AND: begin alu_control = 2'b10; flag_w = 2'b10; end
        CMD_ORR: begin alu_control = 2'b11; flag_w = 2'b10; end
        CMD_CMP: begin alu_control = 2'b01; flag_w = 2'b11; end
        default: begin alu_control = 2'b00; flag_w = 2'b00; end
      endcase
      if (!bus.Funct[0]) flag_w = 2'b00;
    end
  end

  // Held through ALUWB, where ALUOp is already low, so it keys on the instruction alone.
  assign no_write   = (bus.Op == OP_DP) && (cmd == CMD_CMP);
  assign flag_en    = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign cond_latch = (state_q == S_DECODE);

  cond_unit u_cond (
    .clk        (clk),
    .reset_n    (reset_n),
    .cond       (bus.Cond),
    .alu_flags  (bus.ALUFlags),
    .flag_w     (flag_w),
    .flag_en    (flag_en),
    .cond_latch (cond_latch),
    .condex_q   (condex_q)
  );

  assign pcs = ctrl.branch | (ctrl.reg_w & (bus.Rd == 4'd15));

  assign bus.PCWrite    = ctrl.next_pc | (pcs & condex_q);
  assign bus.RegWrite   = ctrl.reg_w & condex_q & ~no_write;
  assign bus.MemWrite   = ctrl.mem_w & condex_q;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};

endmodule

// File: doc/arm_mc_ctrl.md
# arm_mc_ctrl

Multicycle control unit for the ARM datapath: a main FSM that sequences each instruction through fetch, decode, execute and write-back steps, plus the instruction decoder and the conditional-execution/NZCV flag logic. It sits beside the shared-memory multicycle datapath. It drives every mux select and write enable from the registered instruction fields and the ALU flags.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20] (I, cmd[3:0], S/L).
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUSrcA  out  1  ALU input A select: 0 = Rn, 1 = PC.
- ALUSrcB  out  2  ALU input B select: 00 = Rm, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc, RegSrc, ALUControl  out  2 each  decoder outputs.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE: Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECR; Op=00 with Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH (undefined, no side effects).
  - MEMADR → MEMRD if Funct[0]=1, otherwise MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECR/EXECI → ALUWB → FETCH.
  - BRANCH → FETCH.
- State outputs (any field not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add.
  - MEMADR: ALUSrcB=01, ALU add.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW.
  - MEMWR: AdrSrc=1, MemW.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch, ALU add.
- ALU decode, when ALUOp=1 (cmd = Funct[4:1]):
  - 0100 ADD → ALUControl 00, FlagW 11.
  - 0010 SUB → 01, FlagW 11.
  - 0000 AND → 10, FlagW 10.
  - 1100 ORR → 11, FlagW 10.
  - 1010 CMP → 01, FlagW 11, NoWrite=1.
  - Any other cmd → 00, FlagW 00.
  - FlagW is forced to 00 when Funct[0]=0.
- ImmSrc = Op. RegSrc = {Op==01, Op==10}.
- Condition logic:
  - CondEx is evaluated from Cond against the flag register (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 → 0).
  - CondEx is latched into condex_q at the end of DECODE.
- Gated enables:
  - PCS = Branch | (RegW & Rd==15).
  - PCWrite = NextPC | (PCS & condex_q).
  - RegWrite = RegW & condex_q & ~NoWrite.
  - MemWrite = MemW & condex_q.
- Flag update: in EXECR/EXECI with condex_q=1, FlagW[1] loads N,Z and FlagW[0] loads C,V from ALUFlags on the next clock edge.

## Timing
- Reset (async, reset_n low): state = FETCH; flags = 0000; condex_q = 0.
- All outputs are Moore, combinational from state, latched bits and instruction inputs.
- Out of reset, the first cycle is FETCH with IRWrite=1 and PCWrite=1.
- Instruction latency, including FETCH:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles.
  - B: 3 cycles.
  - Undefined (Op=11): 2 cycles.
- Instruction inputs are valid from DECODE onward (IR is loaded at the end of FETCH). Their values during FETCH are ignored except for the ImmSrc/RegSrc pass-through.
- A failed condition does not shorten the sequence. It only suppresses RegWrite, MemWrite, the PC write from PCS, and the flag update.
- CMP: runs the full 4 cycles, updates flags, and RegWrite stays 0 in ALUWB.
- Data-processing with Rd=15 and condex_q=1: PCWrite=1 together with RegWrite in ALUWB.
- If reset_n is asserted mid-instruction, any pending write is abandoned and the next cycle after release is FETCH.

## Structure
- Package arm_ctrl_pkg holds:
  - The state enum.
  - Cond code constants.
  - cmd constants (ADD/SUB/AND/ORR/CMP).
  - ResultSrc/ALUSrcB encodings.
- Sub-module cond_unit contains the flag register, the CondEx evaluation and condex_q. It takes FlagW, the flag-update-enable strobe and ALUFlags.
- The top level contains the FSM and the ALU/immediate decode.

## Test plan
- ADD R1,R2,R3 with Cond=1110 and S=1, ALUFlags=0100 → states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in ALUWB. Flags become 0100.
- LDR with Funct=011001 → 5 states. AdrSrc=1 in MEMRD. RegWrite with ResultSrc=01 in MEMWB. Next cycle is FETCH.
- STR with Cond=0000 while Z=0 → MemWrite stays 0 through MEMWR. Back to FETCH after 4 cycles.
- B with Cond=0001 and Z=0 → PCWrite=1 in BRANCH with ALUSrcB=01. Repeat with Z=1 → PCWrite=0 in BRANCH.
- CMP R1,R2 producing ALUFlags=0110 → NoWrite: RegWrite=0 in ALUWB. Flags become 0110. A following EQ-conditioned ADD writes back.
- reset_n pulsed low during MEMWR → MemWrite drops immediately. State is FETCH and flags are 0000 after release.
